// File: rtl/fir_cfg_core.sv
// fir_cfg_core: 6-tap direct-form FIR filter with shadowed, commit-on-demand
// coefficients. It is programmed through a simple register-write stream.
// The sample path has two registered stages: products, then the sum.
module fir_cfg_core #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 19
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          WrEn,
  input  logic [2:0]    RegAddr,
  input  logic [7:0]    D7_D0,
  input  logic          iValid,
  input  logic [DW-1:0] iX,
  output logic          oValid,
  output logic [OW-1:0] oY,
  output logic          oEn
);

  localparam int NT = 6;
  localparam int PW = DW + CW;

  logic signed [CW-1:0] s_reg [NT];
  logic signed [CW-1:0] c_reg [NT];
  logic signed [DW-1:0] x_reg [NT];
  logic signed [PW-1:0] p_reg [NT];

  logic en_reg;
  logic commit_pend_reg;
  logic clr_pend_reg;
  logic x_valid_reg;
  logic v1_reg;

  logic                   ctrl_wr;
  logic                   accept;
  logic [NT-1:0][PW-1:0]  prod;
  logic [OW-1:0]          sum_next;

  assign ctrl_wr = WrEn && (RegAddr == 3'd6);
  // A pending clear wins over a new sample on the same edge.
  assign accept  = iValid && en_reg && !clr_pend_reg;
  assign oEn     = en_reg;

  // One full-precision signed multiplier per tap. Both operands are widened
  // to the product width, so the product cannot lose bits.
  generate
    for (genvar gi = 0; gi < NT; gi++) begin : g_tap
      assign prod[gi] = $signed({{DW{c_reg[gi][CW-1]}}, c_reg[gi]})
                      * $signed({{CW{x_reg[gi][DW-1]}}, x_reg[gi]});
    end
  endgenerate

  // Adder tree as a simple loop. Each product is sign-extended to the output
  // width first; the 3 guard bits make overflow impossible.
  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NT; i++) begin
      sum_next = sum_next + {{(OW-PW){p_reg[i][PW-1]}}, p_reg[i]};
    end
  end

  // Configuration: shadow writes, CTRL decode, and the one-shot commit/clear flags.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      en_reg          <= 1'b0;
      commit_pend_reg <= 1'b0;
      clr_pend_reg    <= 1'b0;
      for (int i = 0; i < NT; i++) begin
        s_reg[i] <= '0;
        c_reg[i] <= '0;
      end
    end else begin
      commit_pend_reg <= ctrl_wr && D7_D0[1];
      clr_pend_reg    <= ctrl_wr && D7_D0[2];
      if (ctrl_wr) begin
        en_reg <= D7_D0[0];
      end
      for (int i = 0; i < NT; i++) begin
        if (WrEn && (RegAddr == 3'(i))) begin
          s_reg[i] <= D7_D0;
        end
        // A commit copies the pre-edge shadow, so a shadow write on the same
        // edge needs its own commit later.
        if (commit_pend_reg) begin
          c_reg[i] <= s_reg[i];
        end
      end
    end
  end

  // Datapath: delay line shift, product stage, and output stage with valid tracking.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      x_valid_reg <= 1'b0;
      v1_reg      <= 1'b0;
      oValid      <= 1'b0;
      oY          <= '0;
      for (int i = 0; i < NT; i++) begin
        x_reg[i] <= '0;
        p_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        p_reg[i] <= prod[i];
      end
      if (clr_pend_reg) begin
        // Flush the history and everything still in flight.
        x_valid_reg <= 1'b0;
        v1_reg      <= 1'b0;
        oValid      <= 1'b0;
        for (int i = 0; i < NT; i++) begin
          x_reg[i] <= '0;
        end
      end else begin
        if (accept) begin
          x_reg[0] <= iX;
          for (int i = 1; i < NT; i++) begin
            x_reg[i] <= x_reg[i-1];
          end
        end
        x_valid_reg <= accept;
        v1_reg      <= x_valid_reg;
        oValid      <= v1_reg;
        if (v1_reg) begin
          oY <= sum_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_cfg_core.sv
// tb_fir_cfg_core: directed scenarios plus a random phase. Every cycle is
// checked against a transaction-level reference model. The model tracks
// register effects, accepted sample histories and the outputs due on each cycle.
module tb_fir_cfg_core;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        WrEn;
  logic [2:0]  RegAddr;
  logic [7:0]  D7_D0;
  logic        iValid;
  logic [7:0]  iX;
  logic        oValid;
  logic [18:0] oY;
  logic        oEn;

  always #5 CLK = ~CLK;

  fir_cfg_core #(.DW(8), .CW(8), .OW(19)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .WrEn    (WrEn),
    .RegAddr (RegAddr),
    .D7_D0   (D7_D0),
    .iValid  (iValid),
    .iX      (iX),
    .oValid  (oValid),
    .oY      (oY),
    .oEn     (oEn)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int vcount   = 0;
  int first_y  = 0;

  // Reference model state
  int m_s [6];
  int m_c [6];
  int m_h [6];
  bit m_en, m_cp, m_clp, m_v;
  int m_y;

  typedef struct { int h [6]; } acc_t;
  typedef struct { int y; int due; } res_t;
  acc_t acq [$];   // accepted sample histories waiting for their product stage
  res_t rq  [$];   // computed results waiting for their output cycle

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Apply the current inputs to the model for one rising edge.
  task automatic model_edge();
    acc_t a;
    res_t r;
    int   y;
    cyc++;
    if (RSTn !== 1'b1) begin
      for (int i = 0; i < 6; i++) begin
        m_s[i] = 0; m_c[i] = 0; m_h[i] = 0;
      end
      m_en = 0; m_cp = 0; m_clp = 0; m_v = 0; m_y = 0;
      acq.delete();
      rq.delete();
      return;
    end
    if (m_clp) begin
      acq.delete();
      rq.delete();
      for (int i = 0; i < 6; i++) m_h[i] = 0;
    end else begin
      while (acq.size() > 0) begin
        a = acq.pop_front();
        y = 0;
        for (int i = 0; i < 6; i++) y += m_c[i] * a.h[i];
        r.y = y;
        r.due = cyc + 1;
        rq.push_back(r);
      end
    end
    if (m_cp) m_c = m_s;
    if (iValid && m_en && !m_clp) begin
      for (int i = 5; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = int'($signed(iX));
      a.h = m_h;
      acq.push_back(a);
    end
    m_v = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      m_v = 1;
      m_y = r.y;
    end
    if (WrEn && RegAddr < 3'd6) m_s[RegAddr] = int'($signed(D7_D0));
    m_cp  = WrEn && (RegAddr == 3'd6) && D7_D0[1];
    m_clp = WrEn && (RegAddr == 3'd6) && D7_D0[2];
    if (WrEn && RegAddr == 3'd6) m_en = D7_D0[0];
  endtask

  // One clock: model update at the edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check("ovalid", int'(oValid), int'(m_v));
    check("oy", int'($signed(oY)), m_y);
    check("oen", int'(oEn), int'(m_en));
    if (oValid === 1'b1) begin
      if (vcount == 0) first_y = int'($signed(oY));
      vcount++;
    end
  endtask

  task automatic wr(input int a, input int d);
    WrEn = 1'b1;
    RegAddr = a[2:0];
    D7_D0 = d[7:0];
    $display("wr  addr=%0d data=0x%02h", a, d[7:0]);
    cycle();
    WrEn = 1'b0;
  endtask

  task automatic wr_all(input int d);
    for (int i = 0; i < 6; i++) wr(i, d);
  endtask

  task automatic smp(input int x);
    iValid = 1'b1;
    iX = x[7:0];
    $display("smp x=%0d", x);
    cycle();
    iValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic impulse(input int x);
    smp(x);
    repeat (6) smp(0);
    idle(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; WrEn = 1'b0; RegAddr = '0; D7_D0 = '0;
    iValid = 1'b1; iX = 8'd5;

    // Reset held for two cycles while a sample is presented
    cycle();
    cycle();
    check("rst_oen", int'(oEn), 0);
    check("rst_ovalid", int'(oValid), 0);
    RSTn = 1'b1;

    // A stream with EN=0 is ignored
    vcount = 0;
    repeat (5) begin
      iX = 8'($urandom);
      cycle();
    end
    iValid = 1'b0;
    idle(3);
    check("en0_none", vcount, 0);

    // Impulse response
    for (int i = 0; i < 6; i++) wr(i, i + 1);
    wr(6, 3);
    vcount = 0;
    impulse(1);
    check("imp_count", vcount, 7);
    check("imp_first", first_y, 1);

    // A shadow write without a commit does not change the output
    wr(0, 10);
    vcount = 0;
    impulse(1);
    check("shadow_iso", first_y, 1);
    wr(6, 3);
    vcount = 0;
    impulse(1);
    check("commit_c0", first_y, 10);

    // Extreme coefficient and sample values
    wr_all(8'h80);
    wr(6, 3);
    repeat (6) smp(-128);
    idle(3);
    check("ext_max", int'($signed(oY)), 98304);
    wr_all(127);
    wr(6, 3);
    repeat (6) smp(-128);
    idle(3);
    check("ext_min", int'($signed(oY)), -97536);

    // EN drop mid-stream drains exactly two results
    wr_all(1);
    wr(6, 3);
    iValid = 1'b1; iX = 8'd1;
    repeat (8) cycle();
    WrEn = 1'b1; RegAddr = 3'd6; D7_D0 = 8'h00;
    $display("wr  addr=6 data=0x00 (stream running)");
    cycle();
    WrEn = 1'b0;
    vcount = 0;
    repeat (6) cycle();
    iValid = 1'b0;
    check("drain_count", vcount, 2);

    // Clearing the history before a new impulse
    wr(6, 5);
    idle(1);
    vcount = 0;
    impulse(3);
    check("clr_flush", first_y, 3);

    // Commit followed by a same-edge shadow write: c0 keeps the old value
    wr(0, 4);
    wr(6, 3);
    wr(0, 9);
    vcount = 0;
    impulse(1);
    check("race_c0", first_y, 4);

    // Reset with two results in flight
    smp(1);
    smp(2);
    RSTn = 1'b0;
    cycle();
    RSTn = 1'b1;
    vcount = 0;
    idle(4);
    check("rst_flush", vcount, 0);
    wr(6, 1);
    vcount = 0;
    impulse(5);
    check("rst_coef_zero", first_y, 0);
    check("rst_coef_cnt", vcount, 7);

    // Random traffic against the model
    wr(6, 3);
    for (int n = 0; n < 400; n++) begin
      RSTn    = ($urandom % 200) != 0;
      WrEn    = ($urandom % 4) == 0;
      RegAddr = 3'($urandom);
      D7_D0   = 8'($urandom);
      if (RegAddr == 3'd6) begin
        D7_D0[0] = ($urandom % 5) != 0;
        D7_D0[2] = ($urandom % 6) == 0;
      end
      iValid  = ($urandom % 4) != 0;
      iX      = 8'($urandom);
      cycle();
    end
    RSTn = 1'b1; WrEn = 1'b0; iValid = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
